// File: rtl/constant_divider_pkg.sv
// Shared types and helpers for the constant divider.
//   state_t   : controller states (idle / iterating / holding a result)
//   cnt_width : width of a down-counter that must hold values 0 .. n-1
package constant_divider_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/constant_divider_if.sv
// Streaming handshake bundle for the constant divider.
//   master : upstream/downstream side (drives in_valid, data_in, out_ready)
//   slave  : the divider (drives in_ready, out_valid, quotient, remainder)
interface constant_divider_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, quotient, remainder
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, quotient, remainder
  );

endinterface

// File: rtl/constant_divider_div_step.sv
// One combinational restoring-division step (the div_step stage).
//   rem_i     : current partial remainder (always < divisor)
//   bit_i     : next dividend bit shifted in
//   divisor_i : divisor, one bit wider than the data so the compare cannot overflow
//   rem_o     : next partial remainder
//   q_o       : quotient bit produced by this step
module constant_divider_div_step #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic                  bit_i,
  input  logic [DATA_WIDTH:0]   divisor_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic                  q_o
);

  logic [DATA_WIDTH:0] shifted;

  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = (shifted >= divisor_i);
    // Result is below the divisor, so it always fits in DATA_WIDTH bits.
    rem_o   = DATA_WIDTH'(q_o ? (shifted - divisor_i) : shifted);
  end

endmodule

// File: rtl/constant_divider.sv
// Iterative unsigned divider by a compile-time constant, one quotient bit per clock.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : slave side of the valid/ready bundle (dividend in, quotient/remainder out)
module constant_divider
  import constant_divider_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CONSTANT   = 7
) (
  input logic               clk,
  input logic               rst,
  constant_divider_if.slave bus
);

  localparam int unsigned         CntW    = cnt_width(DATA_WIDTH);
  localparam logic [CntW-1:0]     CntMax  = CntW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH:0] Divisor = (DATA_WIDTH + 1)'(CONSTANT);

  if (CONSTANT == 0) begin : g_err_zero
    $error("constant_divider: CONSTANT must be non-zero");
  end
  if ((DATA_WIDTH < 32) && (CONSTANT >= (32'd1 << DATA_WIDTH))) begin : g_err_range
    $error("constant_divider: CONSTANT must be below 2**DATA_WIDTH");
  end

  state_t                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;

  logic [DATA_WIDTH-1:0] step_rem;
  logic                  step_q;

  constant_divider_div_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_div_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[DATA_WIDTH-1]),
    .divisor_i (Divisor),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          dvd_d   = bus.data_in;
          quo_d   = '0;
          rem_d   = '0;
          cnt_d   = CntMax;
          state_d = StBusy;
        end
      end
      StBusy: begin
        dvd_d = dvd_q << 1;
        quo_d = (quo_q << 1) | DATA_WIDTH'(step_q);
        rem_d = step_rem;
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;

endmodule

// File: tb/tb_constant_divider.sv
// Bench for constant_divider: directed cases on an 8-bit / 7 instance and a randomized
// sweep on a 12-bit / 1000 instance, both checked against plain '/' and '%' arithmetic.
module tb_constant_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  constant_divider_if #(.DATA_WIDTH(8))  bus_a ();
  constant_divider_if #(.DATA_WIDTH(12)) bus_b ();

  constant_divider #(
    .DATA_WIDTH (8),
    .CONSTANT   (7)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  constant_divider #(
    .DATA_WIDTH (12),
    .CONSTANT   (1000)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the 8-bit instance. hold: cycles to stall out_ready once the result
  // appears; early: out_ready high from the start; junk: keep in_valid with 200 while busy.
  task automatic run_a(input int d, input int hold, input bit early, input bit junk);
    logic [7:0] eq, er;
    int lat;
    eq = 8'(d / 7);
    er = 8'(d % 7);
    bus_a.data_in   = 8'(d);
    bus_a.in_valid  = 1'b1;
    bus_a.out_ready = early;
    check("a_in_ready_idle", bus_a.in_ready, 1);
    tick();
    if (junk) bus_a.data_in = 8'd200;
    else      bus_a.in_valid = 1'b0;
    lat = 0;
    while (!bus_a.out_valid && lat < 20) begin
      check("a_busy_in_ready", bus_a.in_ready, 0);
      tick();
      lat++;
    end
    check("a_latency", lat, 8);
    check("a_quotient", bus_a.quotient, eq);
    check("a_remainder", bus_a.remainder, er);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("a_hold_valid", bus_a.out_valid, 1);
      check("a_hold_in_ready", bus_a.in_ready, 0);
      check("a_hold_quotient", bus_a.quotient, eq);
      check("a_hold_remainder", bus_a.remainder, er);
    end
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b0;
    check("a_release_valid", bus_a.out_valid, 0);
    check("a_release_in_ready", bus_a.in_ready, 1);
  endtask

  // Randomized sweep on the 12-bit instance with random out_ready.
  task automatic run_b(input int count);
    logic [11:0] pend;
    logic [11:0] cur;
    int sent, got, cyc;
    bit accepted;
    sent = 0;
    got  = 0;
    cyc  = 0;
    pend = '0;
    cur  = '0;
    bus_b.in_valid  = 1'b0;
    bus_b.out_ready = 1'b0;
    while (got < count && cyc < 6000) begin
      if (!bus_b.in_valid && sent < count && ($urandom_range(0, 1) == 1)) begin
        if (sent == 0)      cur = 12'd4095;
        else if (sent == 1) cur = 12'd999;
        else if (sent == 2) cur = 12'd1000;
        else                cur = 12'($urandom_range(0, 4095));
        bus_b.data_in  = cur;
        bus_b.in_valid = 1'b1;
      end
      bus_b.out_ready = 1'($urandom_range(0, 1));
      if (bus_b.out_valid && bus_b.out_ready) begin
        check("b_quotient", bus_b.quotient, 32'(pend) / 1000);
        check("b_remainder", bus_b.remainder, 32'(pend) % 1000);
        got++;
      end
      accepted = bus_b.in_valid && bus_b.in_ready;
      tick();
      cyc++;
      if (accepted) begin
        pend           = cur;
        bus_b.in_valid = 1'b0;
        sent++;
      end
    end
    bus_b.out_ready = 1'b0;
    check("b_result_count", got, count);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bus_a.in_valid  = 1'b1;
    bus_a.data_in   = 8'd99;
    bus_a.out_ready = 1'b0;
    bus_b.in_valid  = 1'b0;
    bus_b.data_in   = '0;
    bus_b.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", bus_a.in_ready, 1);
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_quotient", bus_a.quotient, 0);
    check("rst_remainder", bus_a.remainder, 0);
    check("rst_b_in_ready", bus_b.in_ready, 1);
    check("rst_b_out_valid", bus_b.out_valid, 0);
    rst = 1'b0;
    bus_a.in_valid = 1'b0;
    tick();
    check("rst_no_accept", bus_a.in_ready, 1);

    // Basic and boundary values, out_ready raised before out_valid.
    run_a(100, 0, 1'b1, 1'b0);
    run_a(255, 0, 1'b1, 1'b0);
    run_a(0,   0, 1'b1, 1'b0);
    run_a(6,   0, 1'b1, 1'b0);
    run_a(7,   0, 1'b1, 1'b0);
    // Backpressure.
    run_a(50, 5, 1'b0, 1'b0);
    // Input during busy is ignored, then accepted once idle.
    run_a(50, 2, 1'b0, 1'b1);
    run_a(200, 0, 1'b0, 1'b0);

    // Reset on the third busy cycle aborts the operation.
    bus_a.data_in   = 8'd100;
    bus_a.in_valid  = 1'b1;
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", bus_a.in_ready, 1);
    check("abort_out_valid", bus_a.out_valid, 0);
    check("abort_quotient", bus_a.quotient, 0);
    check("abort_remainder", bus_a.remainder, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen = seen | bus_a.out_valid;
      tick();
    end
    check("abort_no_result", seen, 0);
    bus_a.out_ready = 1'b0;
    run_a(15, 1, 1'b0, 1'b0);

    run_b(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
